// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file.
//   XLEN_DEF  : default data width
//   reg_idx_t : register index for the default 32-entry file
//   ZERO_REG  : index of the hardwired-zero register
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int ZERO_REG = 0;
  typedef logic [4:0] reg_idx_t;
endpackage

// File: rtl/regfile_mp_if.sv
// Register file access bundle: read ports, write ports, scoreboard alloc.
//   rd_addr/rd_data/rd_busy : NRD read ports
//   wr_en/wr_addr/wr_data   : NWR write ports
//   alloc_en/alloc_addr     : destination allocation (sets busy)
//   any_busy                : OR of all busy bits
// master = pipeline side, slave = register file.
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NWR  = 1
);
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     alloc_en;
  logic [AW-1:0]            alloc_addr;
  logic                     any_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_busy, any_busy
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_busy, any_busy
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy scoreboard.
//   clk, rst_n          : clock, async active-low reset
//   wr_en/wr_addr       : writes clear busy of their target
//   alloc_en/alloc_addr : allocation sets busy (wins over a same-cycle clear)
//   busy                : busy vector, bit 0 tied low
//   any_busy            : OR of registered busy bits
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int NWR   = 1,
  parameter int AW    = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR-1:0][AW-1:0] wr_addr,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_addr,
  output logic [NREGS-1:0]       busy,
  output logic                   any_busy
);
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_busy
    logic b;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) b <= 1'b0;
      else begin
        for (int p = 0; p < NWR; p++)
          if (wr_en[p] && wr_addr[p] == AW'(r)) b <= 1'b0;
        // a new producer supersedes the one completing this cycle
        if (alloc_en && alloc_addr == AW'(r)) b <= 1'b1;
      end
    end
    assign busy[r] = b;
  end

  assign any_busy = |busy;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass,
// hardwired x0 and a busy scoreboard for RAW hazard detection.
//   clk, rst_n : clock, async active-low reset (clears data and busy)
//   bus        : regfile_mp_if slave (read/write/alloc ports, any_busy)
// Params: XLEN, NREGS (power of two), NRD, NWR (1 or 2), BYPASS.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0][XLEN-1:0] rf_view;
  logic [NREGS-1:0]           busy;
  logic [NWR-1:0]             wr_hit;

  // forwardable writes; gated by reset so outputs read zero while held
  for (genvar p = 0; p < NWR; p++) begin : g_wr
    assign wr_hit[p] = rst_n && bus.wr_en[p] && (bus.wr_addr[p] != AW'(ZERO_REG));
  end

  assign rf_view[0] = '0;
  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    logic [XLEN-1:0] q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else
        // later iteration overrides: higher port wins on conflict
        for (int p = 0; p < NWR; p++)
          if (bus.wr_en[p] && bus.wr_addr[p] == AW'(r)) q <= bus.wr_data[p];
    end
    assign rf_view[r] = q;
  end

  regfile_scoreboard #(.NREGS(NREGS), .NWR(NWR), .AW(AW)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .alloc_en   (bus.alloc_en),
    .alloc_addr (bus.alloc_addr),
    .busy       (busy),
    .any_busy   (bus.any_busy)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [XLEN-1:0] d;
    logic            b;
    always_comb begin
      d = rf_view[bus.rd_addr[i]];
      b = busy[bus.rd_addr[i]];
      if (BYPASS != 0)
        for (int p = 0; p < NWR; p++)
          if (wr_hit[p] && bus.wr_addr[p] == bus.rd_addr[i]) begin
            d = bus.wr_data[p];
            b = 1'b0;  // data is available this cycle
          end
      if (bus.rd_addr[i] == AW'(ZERO_REG)) begin
        d = '0;
        b = 1'b0;
      end
    end
    assign bus.rd_data[i] = d;
    assign bus.rd_busy[i] = b;
  end
endmodule
